// File: rtl/fetch_queue_unit_pkg.sv
// Shared defaults and types for the instruction fetch queue.
// Holds address/data widths, reset PC, PC step and the fetch entry layout.
package fetch_queue_unit_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam logic [31:0] PC_STEP_DEF = 32'd4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; pointers wrap modulo DEPTH.
// Ports: clk, rst, flush_i, push_i/data_i, pop_i, data_o, empty_o, count_o.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i && !rst) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: issues sequential fetches with reserved
// queue credits, drops stale responses after a branch, and presents the
// head instruction. Ports: clk, rst, branch_taken/branch_address, freeze,
// mem_req_*, mem_rsp_*, out_valid, instruction, pc (head addr + PC_STEP).
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(PC_STEP_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_address,
    input  logic              freeze,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     drop_q, drop_d;

    logic [CW-1:0]     q_count;
    logic              q_empty;
    logic [EW-1:0]     q_head;
    logic [CW:0]       in_use;
    logic              hs;
    logic              rsp_keep;
    logic              rsp_drop;
    logic              push;
    logic              pop;

    // Queue entries plus in-flight requests may never exceed DEPTH.
    assign in_use        = {1'b0, q_count} + {1'b0, outst_q};
    assign mem_req_valid = !rst && !branch_taken
                         && (in_use < (CW+1)'(DEPTH));
    assign mem_req_addr  = fetch_pc_q;
    assign hs            = mem_req_valid && mem_req_ready;

    assign rsp_keep = mem_rsp_valid && (drop_q == '0);
    assign rsp_drop = mem_rsp_valid && (drop_q != '0);
    assign push     = rsp_keep && !branch_taken;
    assign pop      = !q_empty && !freeze && !branch_taken;

    assign out_valid   = !q_empty;
    assign instruction = q_head[DATA_W-1:0];
    assign pc          = q_head[EW-1:DATA_W] + PC_STEP;

    // Responses are in order and every pre-branch request is dropped, so
    // kept responses belong to consecutive addresses from the last target.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        outst_d    = outst_q + CW'(hs) - CW'(mem_rsp_valid);
        if (branch_taken) begin
            fetch_pc_d = branch_address;
            rsp_pc_d   = branch_address;
            drop_d     = outst_d;
        end else begin
            if (hs)       fetch_pc_d = fetch_pc_q + PC_STEP;
            if (rsp_keep) rsp_pc_d   = rsp_pc_q + PC_STEP;
            if (rsp_drop) drop_d     = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (branch_taken),
        .push_i  (push),
        .data_i  ({rsp_pc_q, mem_rsp_data}),
        .pop_i   (pop),
        .data_o  (q_head),
        .empty_o (q_empty),
        .count_o (q_count)
    );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with an in-order memory model.
// Memory answers one cycle after acceptance unless held.
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        freeze;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        out_valid;
    logic [31:0] instruction;
    logic [31:0] pc;

    logic [31:0] pend[$];
    logic        hold;
    int          n_req;
    int          n_chk;
    int          n_pass;

    always #5 clk = ~clk;

    fetch_queue_unit dut (
        .clk            (clk),
        .rst            (rst),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .freeze         (freeze),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .out_valid      (out_valid),
        .instruction    (instruction),
        .pc             (pc)
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %h exp %h", tag, got, exp);
    endtask

    task automatic tick();
        logic        hs;
        logic        rv;
        logic [31:0] a;
        #1;
        hs = mem_req_valid && mem_req_ready;
        rv = mem_rsp_valid;
        a  = mem_req_addr;
        @(posedge clk);
        #1;
        if (rst) begin
            pend.delete();
        end else begin
            if (rv && pend.size() > 0) void'(pend.pop_front());
            if (hs) begin
                pend.push_back(a);
                n_req++;
            end
        end
        mem_rsp_valid = !hold && (pend.size() > 0);
        mem_rsp_data  = (pend.size() > 0) ? mdata(pend[0]) : 32'h0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_out(input string tag);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        check(tag, 64'(out_valid), 64'd1);
    endtask

    initial begin
        n_chk          = 0;
        n_pass         = 0;
        n_req          = 0;
        hold           = 1'b0;
        rst            = 1'b1;
        branch_taken   = 1'b0;
        branch_address = 32'h0;
        freeze         = 1'b0;
        mem_req_ready  = 1'b1;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = 32'h0;

        // reset state and first request
        tick();
        check("rst_outv", 64'(out_valid), 64'd0);
        check("rst_reqv", 64'(mem_req_valid), 64'd0);
        rst = 1'b0;
        #1;
        check("c0_reqv", 64'(mem_req_valid), 64'd1);
        check("c0_addr", 64'(mem_req_addr), 64'h0);

        // streaming, 1-cycle memory
        tick();
        check("c1_outv", 64'(out_valid), 64'd0);
        check("c1_addr", 64'(mem_req_addr), 64'h4);
        tick();
        check("c2_outv", 64'(out_valid), 64'd1);
        check("c2_pc", 64'(pc), 64'h4);
        check("c2_ins", 64'(instruction), 64'(mdata(32'h0)));
        tick();
        check("c3_pc", 64'(pc), 64'h8);
        tick();
        check("c4_pc", 64'(pc), 64'hC);

        // freeze from reset: queue fills, requests stop
        freeze = 1'b1;
        do_reset();
        n_req = 0;
        for (int i = 0; i < 10; i++) tick();
        check("frz_nreq", 64'(n_req), 64'd4);
        check("frz_reqv", 64'(mem_req_valid), 64'd0);
        check("frz_pc", 64'(pc), 64'h4);
        freeze = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("unfrz_v", 64'(out_valid), 64'd1);
            check("unfrz_pc", 64'(pc), 64'(32'(4 * (k + 1))));
            check("unfrz_ins", 64'(instruction), 64'(mdata(32'(4 * k))));
            tick();
        end

        // branch with two requests outstanding
        hold = 1'b1;
        do_reset();
        tick();
        tick();
        hold           = 1'b0;
        branch_taken   = 1'b1;
        branch_address = 32'h100;
        #1;
        check("br_reqv", 64'(mem_req_valid), 64'd0);
        tick();
        branch_taken = 1'b0;
        #1;
        check("br_addr", 64'(mem_req_addr), 64'h100);
        tick();
        check("br_drop1", 64'(out_valid), 64'd0);
        tick();
        check("br_drop2", 64'(out_valid), 64'd0);
        tick();
        check("br_outv", 64'(out_valid), 64'd1);
        check("br_pc", 64'(pc), 64'h104);
        check("br_ins", 64'(instruction), 64'(mdata(32'h100)));

        // branch together with freeze on a non-empty queue
        freeze = 1'b1;
        tick();
        tick();
        check("bf_pre_pc", 64'(pc), 64'h104);
        branch_taken   = 1'b1;
        branch_address = 32'h200;
        tick();
        branch_taken = 1'b0;
        #1;
        check("bf_outv", 64'(out_valid), 64'd0);
        check("bf_reqv", 64'(mem_req_valid), 64'd1);
        check("bf_addr", 64'(mem_req_addr), 64'h200);
        freeze = 1'b0;
        wait_out("bf_seen");
        check("bf_pc", 64'(pc), 64'h204);

        // address wrap
        branch_taken   = 1'b1;
        branch_address = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        #1;
        check("wr_addr0", 64'(mem_req_addr), 64'hFFFF_FFFC);
        tick();
        check("wr_addr1", 64'(mem_req_addr), 64'h0);
        wait_out("wr_seen");
        check("wr_pc", 64'(pc), 64'h0);
        check("wr_ins", 64'(instruction), 64'(mdata(32'hFFFF_FFFC)));

        // reset mid-stream, then a stalled request
        tick();
        check("mr_pre", 64'(out_valid), 64'd1);
        rst = 1'b1;
        tick();
        check("mr_outv", 64'(out_valid), 64'd0);
        check("mr_reqv", 64'(mem_req_valid), 64'd0);
        rst = 1'b0;
        mem_req_ready = 1'b0;
        #1;
        check("mr_addr", 64'(mem_req_addr), 64'h0);
        tick();
        tick();
        check("stl_reqv", 64'(mem_req_valid), 64'd1);
        check("stl_addr", 64'(mem_req_addr), 64'h0);
        check("stl_outv", 64'(out_valid), 64'd0);
        mem_req_ready = 1'b1;
        tick();
        check("stl_next", 64'(mem_req_addr), 64'h4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
